// File: rtl/cpu_pkg.sv
// Shared types and constants for the operand-forwarding scoreboard.
package cpu_pkg;

    localparam int REG_W      = 5;
    // Storage width for the per-entry remaining-latency field; LATW must not exceed this.
    localparam int REM_W      = 4;
    localparam int FWD_SEL_RF = 0;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] wa;
        logic [REM_W-1:0] rem;
    } fwd_entry_t;

    // Remaining latency counts down by one stage, stopping at zero.
    function automatic logic [REM_W-1:0] rem_dec(input logic [REM_W-1:0] r);
        return (r == '0) ? r : r - 1'b1;
    endfunction

endpackage

// File: rtl/fwd_port_match.sv
// Per-read-port priority search over the in-flight entries: youngest match wins.
module fwd_port_match
    import cpu_pkg::*;
#(
    parameter int NSTAGE = 2,
    parameter int SELW   = $clog2(NSTAGE + 1)
) (
    input  fwd_entry_t [NSTAGE-1:0] entries_i,
    input  logic                    rd_used_i,
    input  logic [REG_W-1:0]        rd_addr_i,
    output logic [SELW-1:0]         sel_o,
    output logic                    need_stall_o
);

    // Scan oldest to youngest so the lowest-index match is the one left standing.
    always_comb begin
        sel_o        = SELW'(FWD_SEL_RF);
        need_stall_o = 1'b0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (entries_i[k].valid && rd_used_i &&
                (entries_i[k].wa == rd_addr_i) && (entries_i[k].wa != '0)) begin
                sel_o        = SELW'(k + 1);
                need_stall_o = (entries_i[k].rem != '0);
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding scoreboard: shadow pipeline of in-flight register writes, per-port
// forward selects, load-use stall and a saturating stall-cycle counter.
module fwd_scoreboard
    import cpu_pkg::*;
#(
    parameter int NRD    = 2,
    parameter int NSTAGE = 2,
    parameter int LATW   = 2,
    parameter int CNTW   = 32
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   advance,
    input  logic                                   issue_valid,
    input  logic                                   issue_we,
    input  logic [REG_W-1:0]                       issue_wa,
    input  logic [LATW-1:0]                        issue_lat,
    input  logic [NSTAGE-1:0]                      flush_mask,
    input  logic [NRD-1:0]                         rd_used,
    input  logic [NRD*REG_W-1:0]                   rd_addr,
    output logic [NRD*$clog2(NSTAGE+1)-1:0]        fwd_sel,
    output logic                                   stall,
    output logic [CNTW-1:0]                        stall_cnt
);

    localparam int SELW = $clog2(NSTAGE + 1);

    fwd_entry_t [NSTAGE-1:0] entries_q, entries_d, flushed;
    logic [CNTW-1:0]         stall_cnt_q, stall_cnt_d;
    logic [NRD-1:0]          port_stall;
    logic [LATW-1:0]         lat_eff;
    fwd_entry_t              new_entry;

    // A zero latency request behaves like a single-stage ALU op.
    assign lat_eff = (issue_lat == '0) ? LATW'(1) : issue_lat;

    // Build the entry entering EX/MEM; bubbles and non-writers become invalid entries.
    always_comb begin
        new_entry.valid = issue_valid & issue_we;
        new_entry.wa    = issue_wa;
        new_entry.rem   = REM_W'(lat_eff - LATW'(1));
    end

    // Flush acts on pre-shift indices, then the whole array shifts if the pipe advances.
    always_comb begin
        flushed = entries_q;
        for (int k = 0; k < NSTAGE; k++) begin
            if (flush_mask[k]) flushed[k].valid = 1'b0;
        end
        entries_d = flushed;
        if (advance) begin
            for (int k = NSTAGE - 1; k > 0; k--) begin
                entries_d[k]     = flushed[k-1];
                entries_d[k].rem = rem_dec(flushed[k-1].rem);
            end
            entries_d[0] = new_entry;
        end
    end

    // Entry state register; reset only needs to clear the valid bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NSTAGE; k++) entries_q[k].valid <= 1'b0;
        end else begin
            entries_q <= entries_d;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_port
        fwd_port_match #(
            .NSTAGE (NSTAGE),
            .SELW   (SELW)
        ) u_match (
            .entries_i    (entries_q),
            .rd_used_i    (rd_used[p]),
            .rd_addr_i    (rd_addr[p*REG_W +: REG_W]),
            .sel_o        (fwd_sel[p*SELW +: SELW]),
            .need_stall_o (port_stall[p])
        );
    end

    assign stall     = |port_stall;
    assign stall_cnt = stall_cnt_q;

    // Count stalled cycles, holding at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    end

    // Stall counter register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: directed scenarios followed by random
// traffic, all compared against an instruction-level model of the in-flight writes.
module tb_fwd_scoreboard;

    localparam int NRD    = 2;
    localparam int NSTAGE = 2;
    localparam int LATW   = 2;
    localparam int CNTW   = 2;
    localparam int SELW   = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 advance;
    logic                 issue_valid;
    logic                 issue_we;
    logic [4:0]           issue_wa;
    logic [LATW-1:0]      issue_lat;
    logic [NSTAGE-1:0]    flush_mask;
    logic [NRD-1:0]       rd_used;
    logic [NRD*5-1:0]     rd_addr;
    logic [NRD*SELW-1:0]  fwd_sel;
    logic                 stall;
    logic [CNTW-1:0]      stall_cnt;

    fwd_scoreboard #(
        .NRD    (NRD),
        .NSTAGE (NSTAGE),
        .LATW   (LATW),
        .CNTW   (CNTW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .advance     (advance),
        .issue_valid (issue_valid),
        .issue_we    (issue_we),
        .issue_wa    (issue_wa),
        .issue_lat   (issue_lat),
        .flush_mask  (flush_mask),
        .rd_used     (rd_used),
        .rd_addr     (rd_addr),
        .fwd_sel     (fwd_sel),
        .stall       (stall),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: slot k holds the instruction that has moved k stages past EX.
    // Its result is ready once it has travelled (latency-1) stages.
    bit m_valid [NSTAGE];
    int m_wa    [NSTAGE];
    int m_lat   [NSTAGE];
    int m_cnt;
    bit m_init = 1'b0;
    int exp_sel [NRD];
    bit exp_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_outputs();
        exp_stall = 1'b0;
        for (int p = 0; p < NRD; p++) begin
            bit found = 1'b0;
            int a = int'(rd_addr[p*5 +: 5]);
            exp_sel[p] = 0;
            for (int k = 0; k < NSTAGE; k++) begin
                if (!found && rd_used[p] && m_valid[k] && m_wa[k] == a && a != 0) begin
                    found = 1'b1;
                    exp_sel[p] = k + 1;
                    if (m_lat[k] - 1 - k > 0) exp_stall = 1'b1;
                end
            end
        end
    endtask

    task automatic model_clock(input bit r, input bit adv, input bit iv, input bit we,
                               input int wa, input int lat, input bit [1:0] fm);
        if (r) begin
            for (int k = 0; k < NSTAGE; k++) m_valid[k] = 1'b0;
            m_cnt  = 0;
            m_init = 1'b1;
        end else begin
            if (exp_stall && m_cnt < (1 << CNTW) - 1) m_cnt++;
            for (int k = 0; k < NSTAGE; k++) if (fm[k]) m_valid[k] = 1'b0;
            if (adv) begin
                for (int k = NSTAGE - 1; k > 0; k--) begin
                    m_valid[k] = m_valid[k-1];
                    m_wa[k]    = m_wa[k-1];
                    m_lat[k]   = m_lat[k-1];
                end
                m_valid[0] = iv && we;
                m_wa[0]    = wa;
                m_lat[0]   = (lat == 0) ? 1 : lat;
            end
        end
    endtask

    // One clock: drive on the falling edge, check combinational outputs,
    // clock, update the model, then check the counter just after the edge.
    task automatic step(input bit r, input bit adv, input bit iv, input bit we,
                        input int wa, input int lat, input bit [1:0] fm,
                        input bit [1:0] used, input int a0, input int a1);
        @(negedge clk);
        rst         = r;
        advance     = adv;
        issue_valid = iv;
        issue_we    = we;
        issue_wa    = 5'(wa);
        issue_lat   = LATW'(lat);
        flush_mask  = fm;
        rd_used     = used;
        rd_addr     = {5'(a1), 5'(a0)};
        #1;
        model_outputs();
        if (m_init) begin
            chk("sel0", 32'(fwd_sel[1:0]), exp_sel[0]);
            chk("sel1", 32'(fwd_sel[3:2]), exp_sel[1]);
            chk("stall", 32'(stall), 32'(exp_stall));
        end
        @(posedge clk);
        model_clock(r, adv, iv, we, wa, lat, fm);
        #1;
        chk("stall_cnt", 32'(stall_cnt), m_cnt);
    endtask

    initial begin
        // Reset and idle state.
        step(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        chk("rst_sel", 32'(fwd_sel), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_cnt", 32'(stall_cnt), 0);
        step(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);

        // ALU chain on register 3.
        step(0, 1, 1, 1, 3, 1, 2'b00, 2'b01, 3, 0);
        chk("alu_sel_e0", 32'(fwd_sel[1:0]), 1);
        chk("alu_nostall", 32'(stall), 0);
        step(0, 1, 0, 0, 0, 1, 2'b00, 2'b01, 3, 0);
        chk("alu_sel_e1", 32'(fwd_sel[1:0]), 2);

        // Load-use on register 5 through port 1.
        step(0, 1, 1, 1, 5, 2, 2'b00, 2'b10, 0, 5);
        chk("lu_stall", 32'(stall), 1);
        step(0, 1, 0, 0, 0, 1, 2'b00, 2'b10, 0, 5);
        chk("lu_sel_e1", 32'(fwd_sel[3:2]), 2);
        chk("lu_released", 32'(stall), 0);
        chk("lu_cnt", 32'(stall_cnt), 1);

        // Youngest producer wins; register 0 never forwards.
        step(0, 1, 1, 1, 7, 1, 2'b00, 2'b00, 0, 0);
        step(0, 1, 1, 1, 7, 1, 2'b00, 2'b11, 7, 7);
        chk("prio_sel0", 32'(fwd_sel[1:0]), 1);
        chk("prio_sel1", 32'(fwd_sel[3:2]), 1);
        step(0, 1, 1, 1, 0, 1, 2'b00, 2'b00, 0, 0);
        step(0, 1, 1, 1, 0, 1, 2'b00, 2'b11, 0, 0);
        chk("r0_sel", 32'(fwd_sel), 0);

        // Flush of a not-yet-ready entry while the pipe holds.
        step(0, 1, 1, 1, 4, 2, 2'b00, 2'b00, 0, 0);
        step(0, 0, 0, 0, 0, 1, 2'b01, 2'b01, 4, 0);
        chk("flush_sel", 32'(fwd_sel[1:0]), 0);
        chk("flush_stall", 32'(stall), 0);

        // Flush and issue in the same cycle: old entry dies, new one survives.
        step(0, 1, 1, 1, 4, 1, 2'b00, 2'b00, 0, 0);
        step(0, 1, 1, 1, 4, 1, 2'b01, 2'b01, 4, 0);
        chk("sim_new_e0", 32'(fwd_sel[1:0]), 1);
        step(0, 0, 0, 0, 0, 1, 2'b01, 2'b01, 4, 0);
        chk("sim_e1_empty", 32'(fwd_sel[1:0]), 0);

        // Hold a load-use stall long enough to saturate the 2-bit counter, then reset.
        step(0, 1, 1, 1, 6, 2, 2'b00, 2'b00, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 6, 0);
        chk("cnt_sat", 32'(stall_cnt), 3);
        step(1, 0, 0, 0, 0, 1, 2'b00, 2'b01, 6, 0);
        chk("rst_mid_stall", 32'(stall), 0);
        chk("rst_mid_sel", 32'(fwd_sel), 0);
        chk("rst_mid_cnt", 32'(stall_cnt), 0);

        // Random traffic on a small register set so hazards are frequent.
        for (int i = 0; i < 400; i++) begin
            bit r    = ($urandom_range(0, 49) == 0);
            bit adv  = ($urandom_range(0, 3) != 0);
            bit iv   = ($urandom_range(0, 3) != 0);
            bit we   = ($urandom_range(0, 4) != 0);
            int wa   = int'($urandom_range(0, 7));
            int lat  = int'($urandom_range(0, 3));
            bit [1:0] fm   = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            bit [1:0] used = 2'($urandom_range(0, 3));
            int a0   = int'($urandom_range(0, 7));
            int a1   = int'($urandom_range(0, 7));
            step(r, adv, iv, we, wa, lat, fm, used, a0, a1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
